// File: rtl/ps2_host_transmitter_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE, FAIL} ps2_state_e;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_LAST_TX_IDX = 9;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
endpackage

// File: rtl/ps2_host_transmitter_if.sv
// Processor-side command handshake and completion status.
interface ps2_host_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (output tx_data, tx_valid, input tx_ready, busy, done, error);
  modport slave  (input tx_data, tx_valid, output tx_ready, busy, done, error);
endinterface

// File: rtl/ps2_host_transmitter_sync_edge.sv
// 2-FF synchronizer for a PS/2 pad plus a falling-edge detector on the synchronized value.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);
  logic meta, prev;

  // Idle bus level is high, so all stages reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign fall = prev & ~q;
endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter; drives the open-collector lines only through OEs.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ps2_host_transmitter_if.slave        tx,
  input  logic                         ps2_clk_in,
  input  logic                         ps2_data_in,
  output logic                         ps2_clk_oe,
  output logic                         ps2_data_oe
);
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       bit_idx, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic             done_q, done_d, err_q, err_d;
  logic             clk_s, clk_fall, data_meta, data_s;
  logic             timed_out;

  ps2_sync_edge u_clk_sync (.clk(clk), .rst_n(rst_n), .d(ps2_clk_in), .q(clk_s), .fall(clk_fall));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      data_meta <= ps2_data_in;
      data_s    <= data_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= idx_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Fires two counts early so the extra FAIL cycle lands error exactly
  // TIMEOUT_CYCLES after the request-to-send edge.
  assign timed_out = (cnt == CNT_W'(2));

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    idx_d     = bit_idx;
    byte_d    = byte_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx.tx_valid && tx.tx_ready) begin
          byte_d   = tx.tx_data;
          par_d    = ~^tx.tx_data;
          cnt_d    = CNT_W'(INHIBIT_CYCLES);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt <= CNT_W'(1)) begin
          data_oe_d = 1'b1;
          clk_oe_d  = 1'b0;
          cnt_d     = CNT_W'(TIMEOUT_CYCLES);
          idx_d     = '0;
          state_d   = SHIFT;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      SHIFT: begin
        cnt_d = cnt - CNT_W'(1);
        if (timed_out) begin
          data_oe_d = 1'b0;
          state_d   = FAIL;
        end else if (clk_fall) begin
          idx_d = bit_idx + 4'd1;
          if (bit_idx < 4'd8)      data_oe_d = ~byte_q[bit_idx[2:0]];
          else if (bit_idx == 4'd8) data_oe_d = ~par_q;
          else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        cnt_d = cnt - CNT_W'(1);
        if (timed_out)     state_d = FAIL;
        else if (clk_fall) state_d = data_s ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d = cnt - CNT_W'(1);
        if (timed_out) state_d = FAIL;
        else if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      FAIL: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        err_d     = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is withheld during the completion pulse so the next handshake is a cycle later.
  assign tx.tx_ready = (state == IDLE) && !done_q && !err_q;
  assign tx.busy     = (state != IDLE);
  assign tx.done     = done_q;
  assign tx.error    = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench: open-collector bus model, clocking device model and a bit scoreboard for the transmitter.
module tb_ps2_host_transmitter;
  localparam int INH = 50;
  localparam int TO  = 2000;
  localparam int H   = 20;  // device half-period in clk cycles (scaled-down 40 us clock)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;

  ps2_host_transmitter_if bus ();

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx(bus),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0;
  int hs_cyc = 0;
  bit exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.done)  done_cnt++;
    if (bus.error) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  function automatic void push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(~^b);
    exp_q.push_back(1'b1);
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int g;
    g = 0;
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && g < 100) begin @(negedge clk); g++; end
    push_frame(b);
    hs_cyc = cyc;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask

  task automatic wait_pulse(input bit is_err, input int bound, output bit seen, output int at);
    seen = 1'b0; at = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (is_err ? bus.error : bus.done) begin seen = 1'b1; at = cyc; end
    end
  endtask

  // Device: samples start at the host's clock release, then one bit per rising edge.
  task automatic device(input int nfalls, input bit ack_low,
                        output int inh_len, output int rts_cyc, output int rise_cyc);
    int g;
    bit b;
    inh_len = 0; rts_cyc = 0; rise_cyc = 0; g = 0;
    @(negedge clk);
    while (!ps2_clk_oe && g < 1000) begin @(negedge clk); g++; end
    if (!ps2_clk_oe) begin
      n_cmp++; n_err++;
      $display("FAIL dev_inhibit: clk_oe got 0, expected 1 within 1000 cycles");
      return;
    end
    rise_cyc = cyc;
    while (ps2_clk_oe && inh_len < 4 * INH) begin inh_len++; @(negedge clk); end
    rts_cyc = cyc;
    for (int i = 0; i <= nfalls && i <= 10; i++) begin
      if (i > 0) begin
        dev_clk_low = 1'b1; repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
      end
      repeat (H) @(negedge clk);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL dev_bit%0d: got unexpected bit %b, expected no bit", i, ps2_data_line);
      end else begin
        b = exp_q.pop_front();
        if (ps2_data_line !== b) begin
          n_err++;
          $display("FAIL dev_bit%0d: got %b, expected %b", i, ps2_data_line, b);
        end
      end
    end
    if (nfalls >= 11) begin
      dev_data_low = ack_low;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1; repeat (H) @(negedge clk);
      dev_clk_low = 1'b0; repeat (2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, expected 1", bus.tx_ready); end
    n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %b, expected 0", bus.done); end
    n_cmp++; if (bus.error !== 1'b0)    begin n_err++; $display("FAIL rst_error: got %b, expected 0", bus.error); end
    n_cmp++; if (ps2_clk_oe !== 1'b0)   begin n_err++; $display("FAIL rst_clk_oe: got %b, expected 0", ps2_clk_oe); end
    n_cmp++; if (ps2_data_oe !== 1'b0)  begin n_err++; $display("FAIL rst_data_oe: got %b, expected 0", ps2_data_oe); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send_ed;
    int inh, rts, rise, d0, e0, at;
    bit seen;
    d0 = done_cnt; e0 = err_cnt;
    fork
      device(11, 1'b1, inh, rts, rise);
      begin start_tx(8'hED); wait_pulse(1'b0, 2000, seen, at); end
    join
    repeat (5) @(negedge clk);
    n_cmp++; if (!seen)              begin n_err++; $display("FAIL ed_done_seen: got none, expected done"); end
    n_cmp++; if (inh !== INH)        begin n_err++; $display("FAIL ed_inhibit_len: got %0d, expected %0d", inh, INH); end
    n_cmp++; if (rise !== hs_cyc + 1) begin n_err++; $display("FAIL ed_clk_oe_rise: got cycle %0d, expected %0d", rise, hs_cyc + 1); end
    n_cmp++; if (exp_q.size() != 0)  begin n_err++; $display("FAIL ed_bits_left: got %0d, expected 0", exp_q.size()); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL ed_done_count: got %0d, expected 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0)  begin n_err++; $display("FAIL ed_error_count: got %0d, expected 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    int inh1, rts1, rise1, inh2, rts2, rise2, d0, e0, at1, at2, hs2;
    bit seen1, seen2;
    d0 = done_cnt; e0 = err_cnt; hs2 = 0;
    fork
      begin device(11, 1'b1, inh1, rts1, rise1); device(11, 1'b1, inh2, rts2, rise2); end
      begin
        start_tx(8'h00);
        wait_pulse(1'b0, 2000, seen1, at1);
        start_tx(8'h01);
        hs2 = hs_cyc;
        wait_pulse(1'b0, 2000, seen2, at2);
      end
    join
    repeat (5) @(negedge clk);
    n_cmp++; if (!(seen1 && seen2))   begin n_err++; $display("FAIL b2b_done_seen: got %b%b, expected 11", seen1, seen2); end
    n_cmp++; if (hs2 !== at1 + 1)     begin n_err++; $display("FAIL b2b_handshake: got cycle %0d, expected %0d", hs2, at1 + 1); end
    n_cmp++; if (done_cnt - d0 != 2)  begin n_err++; $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0)   begin n_err++; $display("FAIL b2b_error_count: got %0d, expected 0", err_cnt - e0); end
    n_cmp++; if (exp_q.size() != 0)   begin n_err++; $display("FAIL b2b_bits_left: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_no_ack;
    int inh, rts, rise, d0, at;
    bit seen;
    d0 = done_cnt;
    fork
      device(11, 1'b0, inh, rts, rise);
      begin
        start_tx(8'hF4);
        wait_pulse(1'b1, 2000, seen, at);
        n_cmp++; if (!seen) begin n_err++; $display("FAIL noack_error_seen: got none, expected error"); end
        n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
          n_err++; $display("FAIL noack_oes: got %b, expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clk);
        n_cmp++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL noack_ready: got %b, expected 1", bus.tx_ready); end
      end
    join
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL noack_done_count: got %0d, expected 0", done_cnt - d0); end
    exp_q.delete();
  endtask

  task automatic test_timeout;
    int inh, rts, rise, at;
    bit seen;
    fork
      device(4, 1'b1, inh, rts, rise);
      begin
        start_tx(8'hED);
        wait_pulse(1'b1, INH + TO + 300, seen, at);
        n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
          n_err++; $display("FAIL to_oes: got %b, expected 00", {ps2_clk_oe, ps2_data_oe});
        end
      end
    join
    n_cmp++; if (!seen)          begin n_err++; $display("FAIL to_error_seen: got none, expected error"); end
    n_cmp++; if (at - rts != TO) begin n_err++; $display("FAIL to_latency: got %0d, expected %0d", at - rts, TO); end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int inh, rts, rise, at, d0;
    bit seen;
    fork
      device(6, 1'b1, inh, rts, rise);
      start_tx(8'h0F);
    join
    exp_q.delete();
    n_cmp++; if (ps2_data_oe !== 1'b1) begin n_err++; $display("FAIL mid_pre_data_oe: got %b, expected 1", ps2_data_oe); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      n_err++; $display("FAIL mid_async_oes: got %b, expected 00", {ps2_clk_oe, ps2_data_oe});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.tx_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b, expected 1", bus.tx_ready); end
    n_cmp++; if (bus.busy !== 1'b0)     begin n_err++; $display("FAIL mid_busy: got %b, expected 0", bus.busy); end
    d0 = done_cnt;
    fork
      device(11, 1'b1, inh, rts, rise);
      begin start_tx(8'hF4); wait_pulse(1'b0, 2000, seen, at); end
    join
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL mid_f4_done: got %0d, expected 1", done_cnt - d0); end
    n_cmp++; if (exp_q.size() != 0)  begin n_err++; $display("FAIL mid_f4_bits_left: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_ignore_busy;
    int inh, rts, rise, at, d0;
    bit seen;
    d0 = done_cnt;
    fork
      device(11, 1'b1, inh, rts, rise);
      begin
        start_tx(8'hFF);
        repeat (INH + 100) @(negedge clk);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        n_cmp++; if (bus.tx_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b, expected 0", bus.tx_ready); end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_pulse(1'b0, 2000, seen, at);
      end
    join
    repeat (INH + 20) @(negedge clk);
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL busy_done_count: got %0d, expected 1", done_cnt - d0); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL busy_restart: got busy %b, expected 0", bus.busy); end
    n_cmp++; if (exp_q.size() != 0)  begin n_err++; $display("FAIL busy_bits_left: got %0d, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_ignore_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_host_transmitter.md
# ps2_host_transmitter

Host-to-device PS/2 transmitter. Sends one command byte, for example 0xED (set LEDs) or 0xFF (reset), from the processor side to the keyboard. It shares the open-collector ps2_clk/ps2_data lines with the keyboard receiver. It runs on the system clock, samples the keyboard-generated PS/2 clock through synchronizers, and drives both lines low only through output-enable pins. Completion is reported with a one-cycle done or error pulse.

## Interface
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles from request-to-send to final bus idle (20 ms at 50 MHz).
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte; captured on handshake.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
- ps2_clk_in  in  1  raw PS/2 clock line (pad input).
- ps2_data_in  in  1  raw PS/2 data line (pad input).
- ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: byte sent and acknowledged by the device.
- error  out  1  one-cycle pulse: no acknowledge, or timeout.

## Operation
- Both PS/2 inputs pass through 2-FF synchronizers. fall = synchronized clock was 1 last cycle and is 0 now.
- Frame: start bit 0, D0..D7 LSB first, odd parity (~^byte), stop bit 1, then the device ACK (data low).
- A data bit of 0 is driven as ps2_data_oe=1. A data bit of 1 is driven as ps2_data_oe=0.
- IDLE: both OEs are 0 and tx_ready=1. On handshake, capture the byte and computed parity, load the cycle counter with INHIBIT_CYCLES, and go to INHIBIT.
- INHIBIT: ps2_clk_oe=1. When the counter reaches 0, set ps2_data_oe=1 (start bit), set ps2_clk_oe=0, load the timeout counter, clear bit_idx, and go to SHIFT.
- SHIFT: on each fall, bit_idx increments.
  - On fall with bit_idx 0..7, drive D[bit_idx].
  - On fall with bit_idx 8, drive parity.
  - On fall with bit_idx 9, release data (stop bit), then go to ACK.
- ACK: on the next fall, sample the synchronized data line. A 0 goes to WAIT_IDLE; a 1 goes to FAIL.
- WAIT_IDLE: when both synchronized lines are 1, go to IDLE and pulse done.
- FAIL: release both lines, pulse error, and go to IDLE.
- The timeout counter decrements in SHIFT, ACK and WAIT_IDLE. At 0, go to FAIL.
- Falls seen in IDLE or INHIBIT are ignored. tx_valid while busy is ignored, and the held byte is unaffected.
- The keyboard receiver sees this traffic and must ignore it; that is the integrator's responsibility.

## Timing
- Reset values: tx_ready=1, busy=0, done=0, error=0, ps2_clk_oe=0, ps2_data_oe=0, state IDLE.
- Asserting rst_n=0 mid-transfer releases both lines asynchronously in the same instant.
- Handshake at cycle N gives ps2_clk_oe=1 at N+1. ps2_clk_oe stays high for exactly INHIBIT_CYCLES cycles.
- The data_oe rise and the clk_oe fall occur in the same cycle.
- The data change after each fall lags the raw PS/2 edge by 3 clk cycles: 2 synchronizer stages plus 1 register. This is well inside the device's half-period of at least 30 µs.
- done and error are mutually exclusive. Each is a registered pulse of exactly 1 cycle, asserted in the cycle the FSM returns to IDLE.
- The earliest next handshake is the cycle after done or error.

## Structure
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, SHIFT, ACK, WAIT_IDLE, FAIL;
  - localparams PS2_FRAME_BITS=11 and PS2_LAST_TX_IDX=9;
  - commonly used command constants: 0xED, 0xF4, 0xFF.
- One sub-module, ps2_sync_edge, contains the 2-FF synchronizer plus the falling-edge detector. It is instantiated for the clock line; the data line uses synchronizer-only output.
- Counters: one down-counter sized by $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1), shared between inhibit and timeout. bit_idx is 4-bit.

## Test plan
- Send 0xED with a device model using a 40 µs clock period and ACK=0. Required:
  - clk_oe low for exactly INHIBIT_CYCLES;
  - device samples, on each rising edge, 0,1,0,1,1,0,1,1,1 (start, D0..D7), then parity 1, then stop 1;
  - a single done pulse.
- Send 0x00, then 0x01 back-to-back (second tx_valid asserted the cycle after done). Required: parity bits 1 then 0, two done pulses, no error.
- Device model leaves data high in the ACK slot. Required: error pulse, both OEs 0, tx_ready=1 next cycle.
- Device model stops clocking after D3 (with TIMEOUT_CYCLES=2000 in this bench). Required: error exactly 2000 cycles after the request-to-send edge, both lines released.
- Assert rst_n low in SHIFT after D5. Required: OEs drop to 0 without waiting for a clk edge; after release, tx_ready=1, busy=0, and a new 0xF4 transfer completes with done.
- Pulse tx_valid with 0xAA during SHIFT of 0xFF. Required: the device receives 0xFF only, and exactly one done.
